// File: rtl/lcd1602_face_painter_if.sv
// lcd1602_face_painter_if: parent/painter bus (tick clock, request, face index, LCD byte outputs); master = parent, slave = painter
interface lcd1602_face_painter_if #(
  parameter int quantity_custom_char = 9
);
  localparam int IW = quantity_custom_char > 1 ? $clog2(quantity_custom_char) : 1;
  logic          clk_16ms;
  logic [IW-1:0] num_cust_char;
  logic          start_painting;
  logic          lcd_available;
  logic          rs;
  logic          rw;
  logic [7:0]    data;
  modport master (output clk_16ms, num_cust_char, start_painting, input lcd_available, rs, rw, data);
  modport slave  (input clk_16ms, num_cust_char, start_painting, output lcd_available, rs, rw, data);
endinterface

// File: rtl/lcd1602_face_painter.sv
// lcd1602_face_painter: uploads a 2x2 custom-glyph face to CGRAM 0-3 and places it on both LCD lines
module lcd1602_face_painter #(
  parameter int quantity_custom_char = 9,
  parameter int FACE_COL = 0
) (
  input logic clk,
  input logic reset,
  lcd1602_face_painter_if.slave bus
);
  localparam int IW = quantity_custom_char > 1 ? $clog2(quantity_custom_char) : 1;
  localparam logic [IW:0] QTY = (IW+1)'(quantity_custom_char);
  localparam logic [7:0] COL = 8'(FACE_COL);
  typedef enum logic [2:0] {IDLE, CGRAM_ADDR, CGRAM_DATA, LINE1_ADDR, LINE1_CHARS, LINE2_ADDR, LINE2_CHARS} state_t;
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [IW-1:0] face, face_n;
  logic prev, tick, rs_q, rs_n;
  logic [7:0] data_q, data_n, rom_byte;
  assign tick = bus.clk_16ms & ~prev;
  always_comb begin
    state_n = state;
    idx_n = idx;
    face_n = face;
    if (tick)
      case (state)
        IDLE: if (bus.start_painting) begin
          state_n = CGRAM_ADDR;
          face_n = {1'b0, bus.num_cust_char} < QTY ? bus.num_cust_char : '0;
        end
        CGRAM_ADDR: begin
          state_n = CGRAM_DATA;
          idx_n = '0;
        end
        CGRAM_DATA: begin
          state_n = idx == 5'd31 ? LINE1_ADDR : CGRAM_DATA;
          idx_n = idx + 5'd1;
        end
        LINE1_ADDR: begin
          state_n = LINE1_CHARS;
          idx_n = '0;
        end
        LINE1_CHARS: begin
          state_n = idx[0] ? LINE2_ADDR : LINE1_CHARS;
          idx_n = idx + 5'd1;
        end
        LINE2_ADDR: begin
          state_n = LINE2_CHARS;
          idx_n = '0;
        end
        LINE2_CHARS: begin
          state_n = idx[0] ? IDLE : LINE2_CHARS;
          idx_n = idx + 5'd1;
        end
        default: state_n = IDLE;
      endcase
  end
  assign rom_byte = {3'b000, (idx_n ^ 5'h15) + 5'(face_n)};
  always_comb begin
    rs_n = state_n inside {CGRAM_DATA, LINE1_CHARS, LINE2_CHARS};
    data_n = state_n == CGRAM_ADDR  ? 8'h40 :
             state_n == CGRAM_DATA  ? rom_byte :
             state_n == LINE1_ADDR  ? 8'h80 + COL :
             state_n == LINE1_CHARS ? {7'b0, idx_n[0]} :
             state_n == LINE2_ADDR  ? 8'hC0 + COL :
             state_n == LINE2_CHARS ? {6'b0, 1'b1, idx_n[0]} : 8'h00;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      face <= '0;
      prev <= 1'b0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state <= state_n;
      idx <= idx_n;
      face <= face_n;
      prev <= bus.clk_16ms;
      rs_q <= rs_n;
      data_q <= data_n;
    end
  assign bus.lcd_available = state == IDLE;
  assign bus.rs = rs_q;
  assign bus.rw = 1'b0;
  assign bus.data = data_q;
endmodule

// File: tb/tb_lcd1602_face_painter.sv
// tb_lcd1602_face_painter: directed self-checking bench for lcd1602_face_painter with the built-in ROM
module tb_lcd1602_face_painter;
  localparam int Q = 9;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  lcd1602_face_painter_if #(.quantity_custom_char(Q)) bus();
  lcd1602_face_painter #(.quantity_custom_char(Q), .FACE_COL(0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [8:0] exp_byte(input int f, input int k);
    logic [4:0] r;
    r = 5'((((k - 1) ^ 'h15) + f) & 'h1F);
    if (k == 0) return {1'b0, 8'h40};
    if (k <= 32) return {1'b1, 3'b000, r};
    case (k)
      33: return {1'b0, 8'h80};
      34: return {1'b1, 8'h00};
      35: return {1'b1, 8'h01};
      36: return {1'b0, 8'hC0};
      37: return {1'b1, 8'h02};
      default: return {1'b1, 8'h03};
    endcase
  endfunction

  task automatic do_tick();
    @(negedge clk) bus.clk_16ms = 1'b1;
    repeat (2) @(negedge clk);
    bus.clk_16ms = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    n_checks++;
    if ({bus.lcd_available, bus.rs, bus.rw, bus.data} !== {3'b100, 8'h00}) begin
      n_fail++;
      $display("FAIL %s idle: got avail=%b rs=%b rw=%b data=%h, want avail=1 rs=0 rw=0 data=00", nm, bus.lcd_available, bus.rs, bus.rw, bus.data);
    end
  endtask

  task automatic run_paint(input string nm, input logic [3:0] req, input int f, input bit hold, input int pulse_at, input int chg_at, input int nbytes);
    logic [8:0] e;
    bus.num_cust_char = req;
    bus.start_painting = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      do_tick();
      if (!hold) bus.start_painting = (k + 1 == pulse_at);
      if (k + 1 == chg_at) bus.num_cust_char = ~req;
      e = exp_byte(f, k);
      n_checks++;
      if ({bus.rs, bus.data} !== e) begin
        n_fail++;
        $display("FAIL %s byte %0d: got rs=%b data=%h, want rs=%b data=%h", nm, k, bus.rs, bus.data, e[8], e[7:0]);
      end
      n_checks++;
      if (bus.lcd_available !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy %0d: got avail=%b, want 0", nm, k, bus.lcd_available);
      end
    end
    if (nbytes == 39) begin
      do_tick();
      check_idle({nm, " end"});
    end
  endtask

  task automatic test_reset();
    bus.clk_16ms = 1'b0;
    bus.start_painting = 1'b0;
    bus.num_cust_char = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check_idle("no_start");
    end
  endtask

  task automatic test_face0();
    run_paint("face0", 4'd0, 0, 1'b0, -1, -1, 39);
  endtask

  task automatic test_face8_change();
    run_paint("face8", 4'd8, 8, 1'b0, -1, 5, 39);
  endtask

  task automatic test_handshake();
    run_paint("handshake", 4'd3, 3, 1'b0, -1, -1, 39);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_idle("one_paint");
    end
    run_paint("busy_pulse", 4'd1, 1, 1'b0, 10, -1, 39);
    do_tick();
    check_idle("pulse_ignored");
  endtask

  task automatic test_back_to_back();
    run_paint("b2b", 4'd2, 2, 1'b1, -1, -1, 39);
    do_tick();
    n_checks++;
    if ({bus.lcd_available, bus.rs, bus.data} !== {2'b00, 8'h40}) begin
      n_fail++;
      $display("FAIL b2b restart: got avail=%b rs=%b data=%h, want avail=0 rs=0 data=40", bus.lcd_available, bus.rs, bus.data);
    end
    bus.start_painting = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    run_paint("pre_reset", 4'd4, 4, 1'b0, -1, -1, 20);
    @(negedge clk) reset = 1'b0;
    #1;
    check_idle("reset_mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_paint("restart", 4'd5, 5, 1'b0, -1, -1, 39);
  endtask

  task automatic test_out_of_range();
    run_paint("oor", 4'd15, 0, 1'b0, -1, -1, 39);
  endtask

  initial begin
    test_reset();
    test_face0();
    test_face8_change();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
